rx_msg_fifo: RTL and testbench
==============================

RX_MSG_FIFO -- requirements
Module: rx_msg_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, FIFO depth is 2**DEPTH_LOG2 entries.
REQ-002 Parameter GAP_CYCLES, default 32, number of idle dec_clk cycles that ends a message (4 us at 8 MHz).
REQ-003 Port dec_clk, input, 1, sole clock; 8 MHz decode clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port rx_dword, input, 16, decoded word from the 1553 decoder core.
REQ-006 Port rx_dval, input, 1, one-cycle strobe qualifying rx_dword, rx_csw, rx_dw and rx_perr.
REQ-007 Port rx_csw, input, 1, the word is a command/status word.
REQ-008 Port rx_dw, input, 1, the word is a data word.
REQ-009 Port rx_perr, input, 1, the word failed its parity check.
REQ-010 Port rd_en, input, 1, pops the head entry when rd_valid=1.
REQ-011 Port clr, input, 1, synchronous flush.
REQ-012 Port rd_data, output, 20, head entry {perr, som, csw, dw, dword[15:0]}; show-ahead.
REQ-013 Port rd_valid, output, 1, FIFO not empty.
REQ-014 Port count, output, DEPTH_LOG2+1, current occupancy.
REQ-015 Port overflow, output, 1, sticky flag: a word was dropped because the FIFO was full.
REQ-016 Port msg_done, output, 1, one-cycle pulse at end of message (gap timeout).

Function
REQ-017 Write condition: rx_dval=1 and clr=0 and (count<DEPTH or a pop occurs in the same cycle); the FIFO SHALL store {perr, som, rx_csw, rx_dw, rx_dword}.
REQ-018 Write latency: an entry written at edge N SHALL appear on rd_data/rd_valid after edge N when the FIFO was empty.
REQ-019 Pop condition: rd_en=1 and rd_valid=1; rd_en on an empty FIFO SHALL be ignored with no pointer or count change.
REQ-020 Full and simultaneous push/pop: the push is accepted and count is unchanged. Full with no pop: the word is dropped and overflow is set to 1.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL equal writes minus pops in the range 0..DEPTH.
REQ-022 Message FSM states IDLE and IN_MSG. IDLE->IN_MSG on any rx_dval; IN_MSG->IDLE when the gap counter reaches GAP_CYCLES-1; msg_done pulses for one cycle on that transition.
REQ-023 Gap counter: cleared on every rx_dval, including dropped words; increments each cycle in IN_MSG; held at 0 in IDLE.
REQ-024 som=1 for a word whose rx_dval arrives while the FSM is in IDLE, otherwise 0.
REQ-025 If rx_dval coincides with the timeout cycle, the word SHALL continue the current message: som=0, no msg_done, counter cleared.
REQ-026 clr: pointers, count, overflow and gap counter are zeroed, the FSM goes to IDLE and msg_done=0. clr wins over a simultaneous rx_dval or rd_en.

Reset
REQ-027 While rst_n=0: rd_valid=0, count=0, overflow=0, msg_done=0, FSM=IDLE, gap counter=0, pointers=0, rd_data=0.
REQ-028 Reset asserted mid-message or mid-read SHALL discard all contents immediately; storage RAM contents need not be cleared.

Configuration
REQ-029 Macro RXFIFO_PERR_STORE_EN defined: words with rx_perr=1 are stored with bit 19 = 1.
REQ-030 RXFIFO_PERR_STORE_EN undefined: words with rx_perr=1 are not written, but still restart the gap counter and FSM. Bit 19 of rd_data SHALL always read 0.

Verification
REQ-031 Write 3 words (0x1234 csw, 0xAAAA dw, 0x5555 dw) 20 cycles apart, then idle 40 cycles -> rd_data shows som=1 only on 0x1234; msg_done pulses once, 32 cycles after the last word.
REQ-032 Push 17 words with DEPTH_LOG2=4 and no reads -> count=16, overflow=1; the 17th word is absent; pops return words 1..16 in order.
REQ-033 Full FIFO, rx_dval together with rd_en -> count stays 16, the new word is accepted, overflow stays 0.
REQ-034 Word with rx_perr=1 -> stored with bit19=1 if RXFIFO_PERR_STORE_EN is defined; otherwise count is unchanged but msg_done timing still restarts.
REQ-035 clr asserted together with rx_dval and rd_en while count=5 -> count=0, rd_valid=0, overflow=0; the next word has som=1.
REQ-036 rst_n pulsed low asynchronously mid-message with count=7 -> all outputs zero immediately; after release, the first word has som=1.

Source files
------------

// File: rtl/rx_msg_fifo.sv
// rx_msg_fifo
//   Receive-side message FIFO for a MIL-STD-1553 decoder core.
//   Words from the decoder are tagged with a start-of-message bit and stored
//   in a show-ahead FIFO. A message ends after GAP_CYCLES idle dec_clk
//   cycles with no decoder strobe, and msg_done pulses for one cycle then.
//
//   Entry layout (20 bits): {perr, som, csw, dw, dword[15:0]}
//
//   Build option:
//     RXFIFO_PERR_STORE_EN  defined   -> parity-error words are stored with
//                                        bit 19 set.
//                           undefined -> parity-error words are not stored.
//                                        They still restart the gap timer and
//                                        the message FSM. Bit 19 of rd_data
//                                        always reads 0.

module rx_msg_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 32
) (
  input  logic                  dec_clk,
  input  logic                  rst_n,
  input  logic [15:0]           rx_dword,
  input  logic                  rx_dval,
  input  logic                  rx_csw,
  input  logic                  rx_dw,
  input  logic                  rx_perr,
  input  logic                  rd_en,
  input  logic                  clr,
  output logic [19:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  msg_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  // The gap counter only has to reach GAP_CYCLES-1. The +1 keeps the width
  // legal when GAP_CYCLES is 1.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // Message FSM encoding
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_MSG = 1'b1;

  // Storage and bookkeeping
  logic [19:0]          mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [0:0]           state;
  logic [GAP_W-1:0]     gap_cnt;

  // Per-cycle decisions
  logic                 full;
  logic                 pop;
  logic                 word_ok;
  logic                 push;
  logic                 drop;
  logic                 som;
  logic                 timeout;
  logic                 perr_bit;
  logic [19:0]          wr_entry;

  // Decide what happens this cycle: pop, push or drop, plus the entry to write.
  always_comb begin
    full     = count[DEPTH_LOG2];
    rd_valid = (count != '0);
    pop      = rd_en & rd_valid & ~clr;
`ifdef RXFIFO_PERR_STORE_EN
    word_ok  = 1'b1;
    perr_bit = rx_perr;
`else
    word_ok  = ~rx_perr;
    perr_bit = 1'b0;
`endif
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push     = rx_dval & ~clr & word_ok & (~full | pop);
    drop     = rx_dval & ~clr & word_ok & full & ~pop;
    som      = (state == ST_IDLE);
    // A word arriving on the timeout cycle continues the current message.
    timeout  = (state == ST_IN_MSG) & (gap_cnt == GAP_LAST) & ~rx_dval;
    wr_entry = {perr_bit, som, rx_csw, rx_dw, rx_dword};
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

  // Storage write. The RAM is left out of reset and is only visible through rd_valid.
  always_ff @(posedge dec_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Write pointer. Wraps naturally at DEPTH because it is exactly PTR_W bits wide.
  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: writes minus pops. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag. Only clr or reset clears it.
  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Gap counter: restarts on any strobe (dropped words too), counts only inside a message.
  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (clr) begin
      gap_cnt <= '0;
    end else if (rx_dval) begin
      gap_cnt <= '0;
    end else if (state == ST_IN_MSG) begin
      if (timeout) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end else begin
      gap_cnt <= '0;
    end
  end

  // Message FSM: any strobe opens or extends a message, and a full idle gap closes it.
  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (clr) begin
      state <= ST_IDLE;
    end else if (rx_dval) begin
      state <= ST_IN_MSG;
    end else if (timeout) begin
      state <= ST_IDLE;
    end
  end

  // End-of-message pulse, registered on the IN_MSG->IDLE transition.
  always_ff @(posedge dec_clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_done <= 1'b0;
    end else if (clr) begin
      msg_done <= 1'b0;
    end else begin
      msg_done <= timeout;
    end
  end

endmodule

// File: tb/tb_rx_msg_fifo.sv
// tb_rx_msg_fifo
//   Self-checking bench for rx_msg_fifo. A queue-based reference model tracks
//   FIFO contents, the sticky overflow flag and message boundaries. Boundaries
//   are measured as the number of cycles since the last decoder strobe. Directed
//   scenarios run first, followed by a randomized burst/idle phase.
`timescale 1ns/1ps

module tb_rx_msg_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int GAP        = 32;

  logic                dec_clk = 1'b0;
  logic                rst_n;
  logic [15:0]         rx_dword;
  logic                rx_dval;
  logic                rx_csw;
  logic                rx_dw;
  logic                rx_perr;
  logic                rd_en;
  logic                clr;
  logic [19:0]         rd_data;
  logic                rd_valid;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                msg_done;

  rx_msg_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .GAP_CYCLES(GAP)
  ) dut (
    .dec_clk  (dec_clk),
    .rst_n    (rst_n),
    .rx_dword (rx_dword),
    .rx_dval  (rx_dval),
    .rx_csw   (rx_csw),
    .rx_dw    (rx_dw),
    .rx_perr  (rx_perr),
    .rd_en    (rd_en),
    .clr      (clr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .overflow (overflow),
    .msg_done (msg_done)
  );

  // 10 ns decode clock
  always #5 dec_clk = ~dec_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [19:0] mq[$];
  bit          m_in_msg;
  int          m_cyc;
  int          m_last;
  bit          m_ovf;
  bit          m_done;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_in_msg = 1'b0;
    m_cyc    = 0;
    m_last   = 0;
    m_ovf    = 1'b0;
    m_done   = 1'b0;
  endtask

  // One clock edge of the behavioural model
  task automatic modelEdge(input bit dv, input logic [15:0] w, input bit csw, input bit dw,
                           input bit perr, input bit rden, input bit cl);
    bit          do_pop;
    bit          storable;
    logic [19:0] e;
    m_done = 1'b0;
    if (cl) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_in_msg = 1'b0;
    end else begin
      do_pop   = rden && (mq.size() > 0);
      storable = 1'b0;
      e        = '0;
      if (dv) begin
`ifdef RXFIFO_PERR_STORE_EN
        storable = 1'b1;
        e        = {perr, !m_in_msg, csw, dw, w};
`else
        storable = !perr;
        e        = {1'b0, !m_in_msg, csw, dw, w};
`endif
        m_in_msg = 1'b1;
        m_last   = m_cyc;
      end else if (m_in_msg && (m_cyc - m_last) == GAP) begin
        m_in_msg = 1'b0;
        m_done   = 1'b1;
      end
      if (do_pop) void'(mq.pop_front());
      if (storable) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
      end
    end
    m_cyc++;
  endtask

  task automatic checkAll(input string tag);
    logic [19:0] head;
    head = (mq.size() > 0) ? mq[0] : 20'h0;
    checkOutput($sformatf("%s rd_valid @%0d", tag, m_cyc), rd_valid, mq.size() > 0);
    checkOutput($sformatf("%s count @%0d", tag, m_cyc), count, mq.size());
    checkOutput($sformatf("%s overflow @%0d", tag, m_cyc), overflow, m_ovf);
    checkOutput($sformatf("%s msg_done @%0d", tag, m_cyc), msg_done, m_done);
    checkOutput($sformatf("%s rd_data @%0d", tag, m_cyc), rd_data, head);
  endtask

  // Drive one cycle, advance the model, then check outputs #1 after the edge
  task automatic applyStimulus(input bit dv, input logic [15:0] w, input bit csw, input bit dw,
                               input bit perr, input bit rden, input bit cl);
    rx_dval  = dv;
    rx_dword = w;
    rx_csw   = csw;
    rx_dw    = dw;
    rx_perr  = perr;
    rd_en    = rden;
    clr      = cl;
    @(posedge dec_clk);
    #1;
    modelEdge(dv, w, csw, dw, perr, rden, cl);
    rx_dval = 1'b0;
    rd_en   = 1'b0;
    clr     = 1'b0;
    rx_perr = 1'b0;
    checkAll("cyc");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 16'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic pushWord(input logic [15:0] w, input bit csw, input bit dw);
    applyStimulus(1, w, csw, dw, 0, 0, 0);
  endtask

  task automatic popWord();
    applyStimulus(0, 16'h0, 0, 0, 0, 1, 0);
  endtask

  task automatic doClr();
    applyStimulus(0, 16'h0, 0, 0, 0, 0, 1);
  endtask

  task automatic checkResetZero(input string tag);
    checkOutput({tag, " rd_valid"}, rd_valid, 0);
    checkOutput({tag, " count"}, count, 0);
    checkOutput({tag, " overflow"}, overflow, 0);
    checkOutput({tag, " msg_done"}, msg_done, 0);
    checkOutput({tag, " rd_data"}, rd_data, 0);
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  pulses;
    int  pulse_at;
    bit  burst;
    bit  dv;

    rst_n    = 1'b0;
    rx_dword = '0;
    rx_dval  = 1'b0;
    rx_csw   = 1'b0;
    rx_dw    = 1'b0;
    rx_perr  = 1'b0;
    rd_en    = 1'b0;
    clr      = 1'b0;
    modelReset();
    #12;
    checkResetZero("reset");
    rst_n = 1'b1;
    idle(3);

    // Three-word message, then idle: som only on the first word, one msg_done 32 cycles later
    $display("[TB] message gap scenario");
    doClr();
    pushWord(16'h1234, 1, 0);
    idle(19);
    pushWord(16'hAAAA, 0, 1);
    idle(19);
    pushWord(16'h5555, 0, 1);
    pulses   = 0;
    pulse_at = -1;
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      if (msg_done) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
    end
    checkOutput("gap pulse count", pulses, 1);
    checkOutput("gap pulse timing", pulse_at, 32);
    checkOutput("head 0x1234", rd_data, 20'h61234);
    popWord();
    checkOutput("head 0xAAAA", rd_data, 20'h1AAAA);
    popWord();
    checkOutput("head 0x5555", rd_data, 20'h15555);
    popWord();

    // A word arriving on the timeout cycle continues the message
    $display("[TB] timeout coincidence scenario");
    pushWord(16'h0C0C, 1, 0);
    idle(31);
    pushWord(16'h0D0D, 0, 1);
    checkOutput("no done on coincidence", msg_done, 0);
    checkOutput("coincide head", rd_data, 20'h60C0C);
    popWord();
    checkOutput("coincide second som=0", rd_data, 20'h10D0D);
    popWord();
    idle(40);

    // Overfill: 17 pushes, 16 kept, overflow set, order preserved
    $display("[TB] overflow scenario");
    doClr();
    for (int i = 1; i <= 17; i++) pushWord(16'(16'h0100 + i), 0, 1);
    checkOutput("full count", count, 16);
    checkOutput("full overflow", overflow, 1);
    for (int i = 1; i <= 16; i++) begin
      checkOutput($sformatf("drain word %0d", i), rd_data[15:0], 16'(16'h0100 + i));
      popWord();
    end
    checkOutput("drained count", count, 0);

    // clr wins over a simultaneous write and pop
    $display("[TB] clr priority scenario");
    for (int i = 0; i < 5; i++) pushWord(16'(16'h0700 + i), 0, 1);
    checkOutput("pre-clr count", count, 5);
    applyStimulus(1, 16'h7777, 1, 0, 0, 1, 1);
    checkOutput("clr count", count, 0);
    checkOutput("clr rd_valid", rd_valid, 0);
    checkOutput("clr overflow", overflow, 0);
    pushWord(16'h0ABC, 1, 0);
    checkOutput("som after clr", rd_data[18], 1);
    popWord();

    // Full FIFO with push and pop together: accepted, no overflow
    $display("[TB] full push+pop scenario");
    doClr();
    for (int i = 1; i <= 16; i++) pushWord(16'(16'h0200 + i), 0, 1);
    applyStimulus(1, 16'hBEEF, 0, 1, 0, 1, 0);
    checkOutput("full push+pop count", count, 16);
    checkOutput("full push+pop overflow", overflow, 0);
    for (int i = 2; i <= 16; i++) popWord();
    checkOutput("accepted word at tail", rd_data[15:0], 16'hBEEF);
    popWord();
    idle(40);

    // Parity-error word: stored or dropped per build, gap timer restarts
    $display("[TB] parity error scenario");
    doClr();
    pushWord(16'h0E0E, 0, 1);
    idle(20);
    applyStimulus(1, 16'h0F0F, 0, 1, 1, 0, 0);
`ifdef RXFIFO_PERR_STORE_EN
    checkOutput("perr stored count", count, 2);
`else
    checkOutput("perr dropped count", count, 1);
`endif
    pulses   = 0;
    pulse_at = -1;
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      if (msg_done) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
    end
    checkOutput("perr gap pulse count", pulses, 1);
    checkOutput("perr gap timing", pulse_at, 32);
    popWord();
`ifdef RXFIFO_PERR_STORE_EN
    checkOutput("perr bit19", rd_data[19], 1);
    popWord();
`endif

    // Asynchronous reset mid-message with seven words stored
    $display("[TB] async reset scenario");
    doClr();
    for (int i = 0; i < 7; i++) pushWord(16'(16'h0300 + i), 0, 1);
    checkOutput("pre-reset count", count, 7);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetZero("async reset");
    modelReset();
    #2;
    rst_n = 1'b1;
    pushWord(16'h0321, 1, 0);
    checkOutput("som after reset", rd_data[18], 1);
    popWord();

    // Randomized bursts and idle stretches against the model
    $display("[TB] randomized phase");
    burst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) burst = ~burst;
      dv = burst && ($urandom_range(0, 2) == 0);
      applyStimulus(dv, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
